// File: rtl/fd_pkg.sv
// Shared types and default widths for the fetch-to-decode queue.
// Optional feature macro: FETCHQ_BYPASS_EN (see fetch_queue.sv).
package fd_pkg;

  localparam int unsigned FQ_DEPTH     = 4;
  localparam int unsigned FQ_WORD      = 64;
  localparam int unsigned FQ_INSTR_LEN = 32;

  typedef struct packed {
    logic [FQ_WORD-1:0]      pc;
    logic [FQ_INSTR_LEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } fq_state_e;

endpackage

// File: rtl/fq_storage.sv
// Entry storage for fetch_queue: DEPTH registers, one write port,
// one asynchronous read port. Data is never reset; validity lives in the pointers.
module fq_storage #(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fd_pkg::fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  entry_t                   wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output entry_t                   rdata
);

  entry_t mem [DEPTH];

  // Write the addressed entry on an accepted enqueue.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: circular buffer of {pc, instr}
// with valid/ready handshakes, branch flush and an occupancy FSM.
// Optional macro FETCHQ_BYPASS_EN: an empty queue forwards the enqueue payload
// combinationally to the dequeue side (0-cycle latency).
module fetch_queue
  import fd_pkg::*;
#(
  parameter int unsigned DEPTH     = FQ_DEPTH,
  parameter int unsigned WORD      = FQ_WORD,
  parameter int unsigned INSTR_LEN = FQ_INSTR_LEN
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic [WORD-1:0]              enq_pc,
  input  logic [INSTR_LEN-1:0]         enq_instr,
  output logic                         deq_valid,
  input  logic                         deq_ready,
  output logic [WORD-1:0]              deq_pc,
  output logic [INSTR_LEN-1:0]         deq_instr,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_TOP = CW'(DEPTH - 1);

  typedef struct packed {
    logic [WORD-1:0]      pc;
    logic [INSTR_LEN-1:0] instr;
  } entry_t;

  fq_state_e   state, state_nx;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        run;
  logic        empty, full, byp;
  logic        enq_fire, deq_fire, do_wr, do_rd;
  entry_t      wdata, head;

  assign empty = (state == EMPTY);
  assign full  = (state == FULL);

`ifdef FETCHQ_BYPASS_EN
  assign byp = empty && enq_valid && run && !flush;
`else
  assign byp = 1'b0;
`endif

  assign enq_ready = run && !full;
  assign deq_valid = !empty || byp;
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_valid && deq_ready;
  // A bypassed entry taken by decode this cycle is never written.
  assign do_wr     = enq_fire && !flush && !(byp && deq_ready);
  assign do_rd     = deq_fire && !empty && !flush;

  assign wdata = '{pc: enq_pc, instr: enq_instr};

  fq_storage #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_storage (
    .clk   (clk),
    .we    (do_wr),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head)
  );

  // Head output: stored head, else bypass payload, else zero.
  always_comb begin
    deq_pc    = '0;
    deq_instr = '0;
    if (!empty) begin
      deq_pc    = head.pc;
      deq_instr = head.instr;
    end else if (byp) begin
      deq_pc    = enq_pc;
      deq_instr = enq_instr;
    end
  end

  // Occupancy next-state; flush overrides everything.
  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   if (do_wr) state_nx = PARTIAL;
      PARTIAL: begin
        if (do_wr && !do_rd && count == CNT_TOP)      state_nx = FULL;
        else if (do_rd && !do_wr && count == CNT_ONE) state_nx = EMPTY;
      end
      FULL:    if (do_rd) state_nx = PARTIAL;
      default: state_nx = EMPTY;
    endcase
    if (flush) state_nx = EMPTY;
  end

  // Pointers, occupancy counter, FSM state and the post-reset ready flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= EMPTY;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      run    <= 1'b0;
    end else begin
      run   <= 1'b1;
      state <= state_nx;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
        if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
        count <= count + {{(CW-1){1'b0}}, do_wr} - {{(CW-1){1'b0}}, do_rd};
      end
    end
  end

endmodule
